// File: rtl/flag_mon_pkg.sv
// Shared types and helpers for the flag window monitor.
package flag_mon_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COUNT  = 2'd1,
    REPORT = 2'd2
  } fmon_state_t;

  // Width of the window cycle counter; WIN_LEN >= 2 keeps this at least 1.
  function automatic int unsigned CYC_W(input int unsigned win_len);
    return (win_len <= 32'd2) ? 32'd1 : $clog2(win_len);
  endfunction

endpackage

// File: rtl/flag_edge_detect.sv
// Rising-edge detector: registers the flag and emits a 1-cycle rise pulse.
module flag_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic flag_q, flag_d;

  always_comb begin
    flag_d = d;
    rise   = d & ~flag_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flag_q <= 1'b0;
    end else begin
      flag_q <= flag_d;
    end
  end

endmodule

// File: rtl/flag_window_monitor.sv
// Counts rising edges of flag_in over a WIN_LEN-cycle window and reports over valid/ready.
// Optional macro FLAG_MONITOR_STICKY_EN adds the alarm_sticky output.
module flag_window_monitor
  import flag_mon_pkg::*;
#(
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned WIN_LEN = 16,
  parameter int unsigned THRESH  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flag_in,
  input  logic             win_start,
  input  logic             rpt_ready,
  output logic             rpt_valid,
  output logic [CNT_W-1:0] rpt_count,
  output logic             rpt_alarm,
  output logic             busy
`ifdef FLAG_MONITOR_STICKY_EN
  ,
  output logic             alarm_sticky
`endif
);

  localparam int unsigned    CycW    = CYC_W(WIN_LEN);
  localparam logic [CycW-1:0] CycLast = CycW'(WIN_LEN - 1);
  localparam logic [CNT_W-1:0] CntMax = '1;
  localparam logic [CNT_W-1:0] ThreshV = CNT_W'(THRESH);

  fmon_state_t      state_q, state_d;
  logic [CycW-1:0]  cyc_cnt_q, cyc_cnt_d;
  logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
  logic [CNT_W-1:0] rpt_count_q, rpt_count_d;
  logic             rpt_alarm_q, rpt_alarm_d;
  logic [CNT_W-1:0] edge_cnt_final;
  logic             rise;

  flag_edge_detect u_edge (
    .clk  (clk),
    .rst  (rst),
    .d    (flag_in),
    .rise (rise)
  );

  always_comb begin
    edge_cnt_final = edge_cnt_q;
    if (rise && (edge_cnt_q != CntMax)) begin
      edge_cnt_final = edge_cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d     = state_q;
    cyc_cnt_d   = cyc_cnt_q;
    edge_cnt_d  = edge_cnt_q;
    rpt_count_d = rpt_count_q;
    rpt_alarm_d = rpt_alarm_q;
    unique case (state_q)
      IDLE: begin
        if (win_start) begin
          state_d    = COUNT;
          cyc_cnt_d  = '0;
          edge_cnt_d = '0;
        end
      end
      COUNT: begin
        // A restart wins over everything else, including a close on the same cycle.
        if (win_start) begin
          cyc_cnt_d  = '0;
          edge_cnt_d = '0;
        end else if (cyc_cnt_q == CycLast) begin
          edge_cnt_d  = edge_cnt_final;
          rpt_count_d = edge_cnt_final;
          rpt_alarm_d = (edge_cnt_final >= ThreshV);
          state_d     = REPORT;
        end else begin
          edge_cnt_d = edge_cnt_final;
          cyc_cnt_d  = cyc_cnt_q + CycW'(1);
        end
      end
      REPORT: begin
        if (rpt_ready) begin
          if (win_start) begin
            state_d    = COUNT;
            cyc_cnt_d  = '0;
            edge_cnt_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cyc_cnt_q   <= '0;
      edge_cnt_q  <= '0;
      rpt_count_q <= '0;
      rpt_alarm_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cyc_cnt_q   <= cyc_cnt_d;
      edge_cnt_q  <= edge_cnt_d;
      rpt_count_q <= rpt_count_d;
      rpt_alarm_q <= rpt_alarm_d;
    end
  end

  assign rpt_valid = (state_q == REPORT);
  assign busy      = (state_q == COUNT);
  assign rpt_count = rpt_count_q;
  assign rpt_alarm = rpt_alarm_q;

`ifdef FLAG_MONITOR_STICKY_EN
  logic sticky_q, sticky_d;

  always_comb begin
    sticky_d = sticky_q | ((state_q == REPORT) & rpt_ready & rpt_alarm_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_q <= 1'b0;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  assign alarm_sticky = sticky_q;
`endif

endmodule

// File: tb/tb_flag_window_monitor.sv
// Bench for flag_window_monitor: directed scenarios plus random traffic against a window model.
module tb_flag_window_monitor;

  localparam int unsigned WinLen = 16;

  logic       clk = 1'b0;
  logic       rst, flag_in, win_start, rpt_ready;
  logic       rpt_valid_a, rpt_alarm_a, busy_a;
  logic [7:0] rpt_count_a;
  logic       rpt_valid_b, rpt_alarm_b, busy_b;
  logic [1:0] rpt_count_b;
`ifdef FLAG_MONITOR_STICKY_EN
  logic       sticky_a, sticky_b;
`endif

  always #5 clk = ~clk;

  flag_window_monitor #(.CNT_W(8), .WIN_LEN(WinLen), .THRESH(4)) u_dut_a (
    .clk       (clk),
    .rst       (rst),
    .flag_in   (flag_in),
    .win_start (win_start),
    .rpt_ready (rpt_ready),
    .rpt_valid (rpt_valid_a),
    .rpt_count (rpt_count_a),
    .rpt_alarm (rpt_alarm_a),
    .busy      (busy_a)
`ifdef FLAG_MONITOR_STICKY_EN
    ,
    .alarm_sticky (sticky_a)
`endif
  );

  // Narrow counter instance to exercise saturation.
  flag_window_monitor #(.CNT_W(2), .WIN_LEN(WinLen), .THRESH(3)) u_dut_b (
    .clk       (clk),
    .rst       (rst),
    .flag_in   (flag_in),
    .win_start (win_start),
    .rpt_ready (rpt_ready),
    .rpt_valid (rpt_valid_b),
    .rpt_count (rpt_count_b),
    .rpt_alarm (rpt_alarm_b),
    .busy      (busy_b)
`ifdef FLAG_MONITOR_STICKY_EN
    ,
    .alarm_sticky (sticky_b)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int unsigned sat(input int unsigned v, input int unsigned mx);
    return (v > mx) ? mx : v;
  endfunction

  // Window model: raw edge total per window; saturation applied only when reporting.
  bit          m_open, m_pending, m_prev, m_st_a, m_st_b;
  int unsigned m_elapsed, m_edges, m_rep;

  initial begin
    m_open = 0; m_pending = 0; m_prev = 0; m_st_a = 0; m_st_b = 0;
    m_elapsed = 0; m_edges = 0; m_rep = 0;
  end

  always @(posedge clk) begin : model
    bit e;
    e      = flag_in && !m_prev;
    m_prev = flag_in;
    if (rst) begin
      m_open = 0; m_pending = 0; m_prev = 0; m_st_a = 0; m_st_b = 0;
      m_elapsed = 0; m_edges = 0; m_rep = 0;
    end else if (m_pending) begin
      if (rpt_ready) begin
        if (sat(m_rep, 255) >= 4) m_st_a = 1;
        if (sat(m_rep, 3) >= 3) m_st_b = 1;
        m_pending = 0;
        if (win_start) begin
          m_open = 1; m_elapsed = 0; m_edges = 0;
        end
      end
    end else if (m_open) begin
      if (win_start) begin
        m_elapsed = 0; m_edges = 0;
      end else begin
        if (e) m_edges++;
        if (m_elapsed == WinLen - 1) begin
          m_open = 0; m_pending = 1; m_rep = m_edges;
        end else begin
          m_elapsed++;
        end
      end
    end else if (win_start) begin
      m_open = 1; m_elapsed = 0; m_edges = 0;
    end
  end

  always @(negedge clk) begin : compare
    chk("valid_a", 32'(rpt_valid_a), 32'(m_pending));
    chk("valid_b", 32'(rpt_valid_b), 32'(m_pending));
    chk("busy_a", 32'(busy_a), 32'(m_open));
    chk("busy_b", 32'(busy_b), 32'(m_open));
    if (m_pending) begin
      chk("count_a", 32'(rpt_count_a), sat(m_rep, 255));
      chk("alarm_a", 32'(rpt_alarm_a), 32'(sat(m_rep, 255) >= 4));
      chk("count_b", 32'(rpt_count_b), sat(m_rep, 3));
      chk("alarm_b", 32'(rpt_alarm_b), 32'(sat(m_rep, 3) >= 3));
    end
`ifdef FLAG_MONITOR_STICKY_EN
    chk("sticky_a", 32'(sticky_a), 32'(m_st_a));
    chk("sticky_b", 32'(sticky_b), 32'(m_st_b));
`endif
  end

  // Pulses win_start, plays pat[k] on window cycle k, returns the first report seen.
  task automatic run_window(input logic [15:0] pat, output int lat, output logic [7:0] cnt_a,
                            output logic [1:0] cnt_b, output logic alm_a);
    lat = 0; cnt_a = '0; cnt_b = '0; alm_a = 1'b0;
    @(negedge clk);
    win_start = 1'b1;
    flag_in   = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      win_start = 1'b0;
      flag_in   = (i <= 16) ? pat[i-1] : 1'b0;
      if (rpt_valid_a) begin
        lat = i; cnt_a = rpt_count_a; cnt_b = rpt_count_b; alm_a = rpt_alarm_a;
        break;
      end
    end
  endtask

  int         lat;
  logic [7:0] ca;
  logic [1:0] cb;
  logic       aa;

  initial begin
    rst = 1'b1; flag_in = 1'b0; win_start = 1'b0; rpt_ready = 1'b0;

    // Reset held 3 cycles with the flag toggling.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      flag_in = ~flag_in;
      chk("rst_valid", 32'(rpt_valid_a), 0);
      chk("rst_busy", 32'(busy_a), 0);
      chk("rst_count", 32'(rpt_count_a), 0);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      flag_in = ~flag_in;
      chk("idle_no_report", 32'(rpt_valid_a), 0);
    end
    @(negedge clk);
    flag_in = 1'b0;

    // Three edges, consumer always ready.
    rpt_ready = 1'b1;
    run_window(16'b0000_0001_0010_0100, lat, ca, cb, aa);
    chk("t2_latency", 32'(lat), 17);
    chk("t2_count", 32'(ca), 3);
    chk("t2_alarm", 32'(aa), 0);
    @(negedge clk);
    chk("t2_one_cycle", 32'(rpt_valid_a), 0);

    // Edges on the first and last window cycles count.
    run_window(16'b1000_0010_0001_0001, lat, ca, cb, aa);
    chk("t3_count", 32'(ca), 4);
    chk("t3_alarm", 32'(aa), 1);
    chk("t3_count_b", 32'(cb), 3);
    @(negedge clk);

    // Backpressure: report held 10 cycles, win_start ignored.
    rpt_ready = 1'b0;
    run_window(16'b0101_0101_0100_0000, lat, ca, cb, aa);
    chk("t4_count", 32'(ca), 5);
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      win_start = (j == 4);
      chk("t4_held_valid", 32'(rpt_valid_a), 1);
      chk("t4_held_count", 32'(rpt_count_a), 5);
      chk("t4_held_alarm", 32'(rpt_alarm_a), 1);
    end
    @(negedge clk);
    win_start = 1'b0;
    rpt_ready = 1'b1;
    @(negedge clk);
    chk("t4_idle_valid", 32'(rpt_valid_a), 0);
    chk("t4_idle_busy", 32'(busy_a), 0);
`ifdef FLAG_MONITOR_STICKY_EN
    chk("t4_sticky", 32'(sticky_a), 1);
`endif

    // Toggling every cycle: 8 edges, narrow counter saturates at 3.
    run_window(16'hAAAA, lat, ca, cb, aa);
    chk("t5_count_a", 32'(ca), 8);
    chk("t5_count_b", 32'(cb), 3);
    @(negedge clk);

    // Restart mid-window: only the restarted window's edges are reported.
    win_start = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      win_start = 1'b0;
      flag_in   = (i % 2 == 0);
    end
    run_window(16'b0000_0000_0100_0010, lat, ca, cb, aa);
    chk("t5_restart_lat", 32'(lat), 17);
    chk("t5_restart_count", 32'(ca), 2);
    @(negedge clk);

    // Reset mid-window.
    win_start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      win_start = 1'b0;
    end
    chk("t6_busy_before", 32'(busy_a), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t6_count_valid", 32'(rpt_valid_a), 0);
    chk("t6_count_busy", 32'(busy_a), 0);

    // Reset mid-report.
    rpt_ready = 1'b0;
    run_window(16'b0001_0001_0001_0001, lat, ca, cb, aa);
    chk("t6_rep_valid_before", 32'(rpt_valid_a), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rpt_ready = 1'b1;
    chk("t6_rep_valid", 32'(rpt_valid_a), 0);
    chk("t6_rep_busy", 32'(busy_a), 0);
`ifdef FLAG_MONITOR_STICKY_EN
    chk("t6_sticky_cleared", 32'(sticky_a), 0);
`endif

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      flag_in   = 1'($urandom_range(0, 1));
      win_start = ($urandom_range(0, 19) == 0);
      rpt_ready = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 299) == 0);
    end
    @(negedge clk);
    rst = 1'b0; win_start = 1'b0;
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
